// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between instruction fetch and data ports
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              state_q;
  logic [3:0]          lat_cnt_q;
  logic [3:0]          starve_cnt_q;
  logic                owner_dm_q;
  logic                wr_q;
  logic                if_ready_q;
  logic                dm_ready_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   dm_rdata_q;

  logic                dm_any_d;
  logic                grant_dm_d;
  logic                grant_if_d;

  // Arbitration decode: data wins unless fetch has been passed over STARVE_LIMIT times
  always_comb begin
    dm_any_d   = dm_read | dm_write;
    grant_dm_d = dm_any_d && (starve_cnt_q < 4'(STARVE_LIMIT));
    grant_if_d = !grant_dm_d && if_req;
  end

  // Access sequencer: grant in IDLE, count latency in ACCESS, pulse ready in RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      owner_dm_q   <= 1'b0;
      wr_q         <= 1'b0;
      if_ready_q   <= 1'b0;
      dm_ready_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (grant_dm_d) begin
            state_q     <= S_ACCESS;
            lat_cnt_q   <= 4'(MEM_LATENCY);
            owner_dm_q  <= 1'b1;
            wr_q        <= dm_write;
            mem_en_q    <= 1'b1;
            mem_we_q    <= dm_write;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
            if (if_req) begin
              starve_cnt_q <= starve_cnt_q + 4'd1;
            end
          end else if (grant_if_d) begin
            state_q      <= S_ACCESS;
            lat_cnt_q    <= 4'(MEM_LATENCY);
            owner_dm_q   <= 1'b0;
            wr_q         <= 1'b0;
            mem_en_q     <= 1'b1;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= if_addr;
            mem_wdata_q  <= dm_wdata;
            starve_cnt_q <= '0;
          end
        end
        S_ACCESS: begin
          lat_cnt_q <= lat_cnt_q - 4'd1;
          if (lat_cnt_q == 4'd1) begin
            state_q <= S_RESP;
            if (owner_dm_q) begin
              dm_ready_q <= 1'b1;
              if (!wr_q) begin
                dm_rdata_q <= mem_rdata;
              end
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign stall_if  = if_req & ~if_ready_q;
  assign stall_mem = (dm_read | dm_write) & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (latency 2 and latency 1 instances)
module tb_mem_port_arbiter;

  localparam int STARVE = 3;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_read;
  logic        dm_write;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;

  logic [31:0] if_rdata_w  [2];
  logic        if_ready_w  [2];
  logic [31:0] dm_rdata_w  [2];
  logic        dm_ready_w  [2];
  logic        mem_en_w    [2];
  logic        mem_we_w    [2];
  logic [31:0] mem_addr_w  [2];
  logic [31:0] mem_wdata_w [2];
  logic [31:0] mem_rdata_w [2];
  logic        stall_if_w  [2];
  logic        stall_mem_w [2];
  logic        busy_w      [2];

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C22_0004;
    return {a[15:0], ~a[15:0]};
  endfunction

  assign mem_rdata_w[0] = mem_func(mem_addr_w[0]);
  assign mem_rdata_w[1] = mem_func(mem_addr_w[1]);

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(STARVE)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_w[0]), .if_ready(if_ready_w[0]),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata_w[0]), .dm_ready(dm_ready_w[0]),
    .mem_en(mem_en_w[0]), .mem_we(mem_we_w[0]), .mem_addr(mem_addr_w[0]),
    .mem_wdata(mem_wdata_w[0]), .mem_rdata(mem_rdata_w[0]),
    .stall_if(stall_if_w[0]), .stall_mem(stall_mem_w[0]), .busy(busy_w[0])
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(STARVE)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_w[1]), .if_ready(if_ready_w[1]),
    .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata_w[1]), .dm_ready(dm_ready_w[1]),
    .mem_en(mem_en_w[1]), .mem_we(mem_we_w[1]), .mem_addr(mem_addr_w[1]),
    .mem_wdata(mem_wdata_w[1]), .mem_rdata(mem_rdata_w[1]),
    .stall_if(stall_if_w[1]), .stall_mem(stall_mem_w[1]), .busy(busy_w[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: each access is a grant timestamp; outputs follow from cycle offsets.
  int          lat     [2] = '{2, 1};
  bit          m_act   [2];
  longint      m_g     [2];
  bit          m_own_dm[2];
  bit          m_wr    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_ifr   [2];
  logic [31:0] m_dmr   [2];
  int          m_starve[2];
  longint      cyc = 0;
  bit          model_ok = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_act[k] = 0; m_starve[k] = 0;
        m_addr[k] = '0; m_wdata[k] = '0; m_ifr[k] = '0; m_dmr[k] = '0;
      end else begin
        if (m_act[k] && cyc == m_g[k] + lat[k]) begin
          if (m_own_dm[k]) begin
            if (!m_wr[k]) m_dmr[k] = mem_func(m_addr[k]);
          end else begin
            m_ifr[k] = mem_func(m_addr[k]);
          end
        end
        if (!m_act[k] || (cyc - m_g[k]) >= lat[k] + 2) begin
          if ((dm_read || dm_write) && m_starve[k] < STARVE) begin
            m_act[k] = 1; m_g[k] = cyc; m_own_dm[k] = 1; m_wr[k] = dm_write;
            m_addr[k] = dm_addr; m_wdata[k] = dm_wdata;
            if (if_req) m_starve[k]++;
          end else if (if_req) begin
            m_act[k] = 1; m_g[k] = cyc; m_own_dm[k] = 0; m_wr[k] = 0;
            m_addr[k] = if_addr; m_wdata[k] = dm_wdata;
            m_starve[k] = 0;
          end
        end
      end
    end
    if (rst) model_ok = 1;
    cyc++;
  end

  bit log_en = 0;
  bit grant_log[$];

  // Compare process: every cycle after the first reset edge, both DUTs against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int k = 0; k < 2; k++) begin
        automatic longint ph = cyc - m_g[k];
        automatic bit in_acc = m_act[k] && ph >= 1 && ph <= lat[k] + 1;
        automatic bit e_en   = m_act[k] && ph == 1;
        automatic bit e_we   = e_en && m_wr[k];
        automatic bit e_rdy  = m_act[k] && ph == lat[k] + 1;
        automatic bit e_ifr  = e_rdy && !m_own_dm[k];
        automatic bit e_dmr  = e_rdy && m_own_dm[k];
        chk($sformatf("d%0d.busy", k),      32'(busy_w[k]),     32'(in_acc));
        chk($sformatf("d%0d.mem_en", k),    32'(mem_en_w[k]),   32'(e_en));
        chk($sformatf("d%0d.mem_we", k),    32'(mem_we_w[k]),   32'(e_we));
        chk($sformatf("d%0d.if_ready", k),  32'(if_ready_w[k]), 32'(e_ifr));
        chk($sformatf("d%0d.dm_ready", k),  32'(dm_ready_w[k]), 32'(e_dmr));
        chk($sformatf("d%0d.mem_addr", k),  mem_addr_w[k],      m_addr[k]);
        chk($sformatf("d%0d.if_rdata", k),  if_rdata_w[k],      m_ifr[k]);
        chk($sformatf("d%0d.dm_rdata", k),  dm_rdata_w[k],      m_dmr[k]);
        chk($sformatf("d%0d.stall_if", k),  32'(stall_if_w[k]), 32'(if_req & ~e_ifr));
        chk($sformatf("d%0d.stall_mem", k), 32'(stall_mem_w[k]), 32'((dm_read | dm_write) & ~e_dmr));
        if (e_we) chk($sformatf("d%0d.mem_wdata", k), mem_wdata_w[k], m_wdata[k]);
      end
      if (log_en && mem_en_w[0]) grant_log.push_back(mem_addr_w[0] == 32'h300);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; if_req = 0; dm_read = 0; dm_write = 0;
    tick();
    tick();
    chk("rst.busy", 32'(busy_w[0]), 32'd0);
    chk("rst.mem_en", 32'(mem_en_w[0]), 32'd0);
    rst = 0;
  endtask

  initial begin
    bit found;
    rst = 1; if_req = 1; if_addr = 32'h40;
    dm_read = 0; dm_write = 0; dm_addr = '0; dm_wdata = '0;

    // Reset held two cycles with a fetch pending, then a single fetch of 0x40
    tick();
    tick();
    chk("reset.mem_en",   32'(mem_en_w[0]),   32'd0);
    chk("reset.busy",     32'(busy_w[0]),     32'd0);
    chk("reset.if_ready", 32'(if_ready_w[0]), 32'd0);
    chk("reset.mem_addr", mem_addr_w[0],      32'd0);
    chk("reset.if_rdata", if_rdata_w[0],      32'd0);
    rst = 0;
    tick();
    chk("fetch.c1.mem_en",   32'(mem_en_w[0]),   32'd1);
    chk("fetch.c1.mem_addr", mem_addr_w[0],      32'h40);
    chk("fetch.c1.stall_if", 32'(stall_if_w[0]), 32'd1);
    tick();
    chk("fetch.c2.mem_en",   32'(mem_en_w[0]),   32'd0);
    chk("fetch.c2.mem_addr", mem_addr_w[0],      32'h40);
    chk("fetch.c2.if_ready", 32'(if_ready_w[0]), 32'd0);
    tick();
    chk("fetch.c3.if_ready", 32'(if_ready_w[0]), 32'd1);
    chk("fetch.c3.if_rdata", if_rdata_w[0],      32'h8C22_0004);
    chk("fetch.c3.stall_if", 32'(stall_if_w[0]), 32'd0);
    if_req = 0;
    tick();
    chk("fetch.c4.if_ready", 32'(if_ready_w[0]), 32'd0);

    // Data write of 0xDEADBEEF to 0x100
    do_reset();
    dm_write = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    tick();
    chk("wr.c1.mem_en",    32'(mem_en_w[0]), 32'd1);
    chk("wr.c1.mem_we",    32'(mem_we_w[0]), 32'd1);
    chk("wr.c1.mem_wdata", mem_wdata_w[0],   32'hDEAD_BEEF);
    chk("wr.c1.mem_addr",  mem_addr_w[0],    32'h100);
    tick();
    tick();
    chk("wr.c3.dm_ready", 32'(dm_ready_w[0]), 32'd1);
    chk("wr.c3.dm_rdata", dm_rdata_w[0],      32'd0);
    dm_write = 0;
    tick();

    // Contention with starvation guard: expect DM,DM,DM,IF,DM,DM
    do_reset();
    if_req = 1; if_addr = 32'h200; dm_read = 1; dm_addr = 32'h300;
    log_en = 1;
    for (int i = 0; i < 24; i++) tick();
    log_en = 0;
    chk("starve.count", 32'(grant_log.size()), 32'd6);
    if (grant_log.size() >= 6) begin
      chk("starve.g0", 32'(grant_log[0]), 32'd1);
      chk("starve.g1", 32'(grant_log[1]), 32'd1);
      chk("starve.g2", 32'(grant_log[2]), 32'd1);
      chk("starve.g3", 32'(grant_log[3]), 32'd0);
      chk("starve.g4", 32'(grant_log[4]), 32'd1);
      chk("starve.g5", 32'(grant_log[5]), 32'd1);
    end
    chk("starve.dm_rdata", dm_rdata_w[0], 32'h0300_FCFF);
    chk("starve.if_rdata", if_rdata_w[0], 32'h0200_FDFF);
    if_req = 0; dm_read = 0;
    tick();

    // Reset in the second ACCESS cycle of a read, then a fresh fetch
    do_reset();
    dm_read = 1; dm_addr = 32'h80;
    tick();
    chk("midrst.c1.mem_en", 32'(mem_en_w[0]), 32'd1);
    tick();
    rst = 1; dm_read = 0;
    tick();
    chk("midrst.dm_ready", 32'(dm_ready_w[0]), 32'd0);
    chk("midrst.busy",     32'(busy_w[0]),     32'd0);
    chk("midrst.mem_addr", mem_addr_w[0],      32'd0);
    rst = 0; if_req = 1; if_addr = 32'h44;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (if_ready_w[0]) found = 1;
    end
    chk("midrst.fetch_done", 32'(found), 32'd1);
    chk("midrst.if_rdata", if_rdata_w[0], 32'h0044_FFBB);
    if_req = 0;
    tick();

    // Simultaneous read and write at 0x8 is a write
    do_reset();
    dm_read = 1; dm_write = 1; dm_addr = 32'h8; dm_wdata = 32'h1234_5678;
    tick();
    chk("rw.d1.mem_we",    32'(mem_we_w[1]), 32'd1);
    chk("rw.d1.mem_wdata", mem_wdata_w[1],   32'h1234_5678);
    chk("rw.d0.mem_we",    32'(mem_we_w[0]), 32'd1);
    tick();
    chk("rw.d1.dm_ready", 32'(dm_ready_w[1]), 32'd1);
    chk("rw.d1.dm_rdata", dm_rdata_w[1],      32'd0);
    tick();
    chk("rw.d0.dm_ready", 32'(dm_ready_w[0]), 32'd1);
    dm_read = 0; dm_write = 0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
